// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed 7-segment display bus as seen by the scan decoder, plus the
// decoded frame results it publishes back.
interface seg7_scan_decoder_if;
  logic [6:0] seg_in;
  logic       dig0;
  logic       dig1;
  logic       dig2;
  logic       dig3;
  logic       frame_valid;
  logic [6:0] bottle_count;
  logic [6:0] cork_count;
  logic       frame_err;
  logic       bus_err;
  logic       stale;

  modport master (
    output seg_in, dig0, dig1, dig2, dig3,
    input  frame_valid, bottle_count, cork_count, frame_err, bus_err, stale
  );

  modport slave (
    input  seg_in, dig0, dig1, dig2, dig3,
    output frame_valid, bottle_count, cork_count, frame_err, bus_err, stale
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers the four BCD digits from a time-multiplexed 7-segment bus and
// publishes bottle/cork counts once every digit has been captured.
module seg7_scan_decoder #(
  parameter int SETTLE         = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int STALE_CYCLES   = 65535
) (
  input logic                clk,
  input logic                rst,
  seg7_scan_decoder_if.slave bus
);

  localparam logic [7:0]  SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [19:0] STALE_MAX = 20'(STALE_CYCLES);

  // {invalid, value}; anything off-table decodes to 0 and is flagged
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0111111: decode = {1'b0, 4'd0};
      7'b0000110: decode = {1'b0, 4'd1};
      7'b1011011: decode = {1'b0, 4'd2};
      7'b1001111: decode = {1'b0, 4'd3};
      7'b1100110: decode = {1'b0, 4'd4};
      7'b1101101: decode = {1'b0, 4'd5};
      7'b1111101: decode = {1'b0, 4'd6};
      7'b0000111: decode = {1'b0, 4'd7};
      7'b1111111: decode = {1'b0, 4'd8};
      7'b1101111: decode = {1'b0, 4'd9};
      default:    decode = {1'b1, 4'd0};
    endcase
  endfunction

  logic [6:0]      r_seg, r_seg_prev;
  logic [3:0]      r_en, r_en_prev;
  logic [7:0]      r_cnt;
  logic [3:0]      r_mask, r_inv;
  logic [3:0][3:0] r_val;
  logic            r_frame_valid, r_frame_err, r_bus_err;
  logic [6:0]      r_bottle, r_cork;
  logic [19:0]     r_stale_cnt;

  logic       w_en_multi, w_en_one, w_same, w_publish;
  logic [7:0] w_cnt_nxt;
  logic [3:0] w_mask_eff, w_cap_vec;
  logic [4:0] w_dec;
  logic [6:0] w_bottle, w_cork;

  always_comb begin
    w_en_multi = |(r_en & (r_en - 4'd1));
    w_en_one   = (r_en != 4'd0) && !w_en_multi;
    w_same     = (r_en == r_en_prev) && (r_seg == r_seg_prev);
    w_cnt_nxt  = 8'd0;
    if (w_en_one && w_same)
      w_cnt_nxt = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    w_publish  = &r_mask;
    // a publish frees every slot this cycle, so a coincident capture lands in the next frame
    w_mask_eff = w_publish ? 4'd0 : r_mask;
    w_cap_vec  = 4'd0;
    if (w_en_one && (w_cnt_nxt == SETTLE_M1))
      w_cap_vec = r_en & ~w_mask_eff;
    w_dec      = decode(r_seg);
    w_bottle   = {3'b0, r_val[0]} * 7'd10 + {3'b0, r_val[1]};
    w_cork     = {3'b0, r_val[2]} * 7'd10 + {3'b0, r_val[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg         <= '0;
      r_seg_prev    <= '0;
      r_en          <= '0;
      r_en_prev     <= '0;
      r_cnt         <= '0;
      r_mask        <= '0;
      r_inv         <= '0;
      r_val         <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_bus_err     <= 1'b0;
      r_bottle      <= '0;
      r_cork        <= '0;
      r_stale_cnt   <= '0;
    end else begin
      r_seg      <= SEG_ACTIVE_LOW ? ~bus.seg_in : bus.seg_in;
      r_en       <= ~{bus.dig3, bus.dig2, bus.dig1, bus.dig0};
      r_seg_prev <= r_seg;
      r_en_prev  <= r_en;
      r_cnt      <= w_cnt_nxt;
      if (w_en_multi)
        r_bus_err <= 1'b1;

      r_mask <= w_mask_eff | w_cap_vec;
      r_inv  <= (w_publish ? 4'd0 : r_inv) | (w_dec[4] ? w_cap_vec : 4'd0);
      for (int i = 0; i < 4; i++)
        if (w_cap_vec[i]) r_val[i] <= w_dec[3:0];

      r_frame_valid <= w_publish;
      if (w_publish) begin
        r_frame_err <= |r_inv;
        if (!(|r_inv)) begin
          r_bottle <= w_bottle;
          r_cork   <= w_cork;
        end
      end

      if (r_frame_valid)
        r_stale_cnt <= '0;
      else if (r_stale_cnt != STALE_MAX)
        r_stale_cnt <= r_stale_cnt + 20'd1;
    end
  end

  assign bus.frame_valid  = r_frame_valid;
  assign bus.bottle_count = r_bottle;
  assign bus.cork_count   = r_cork;
  assign bus.frame_err    = r_frame_err;
  assign bus.bus_err      = r_bus_err;
  assign bus.stale        = (r_stale_cnt == STALE_MAX);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: vector table, hand-written corner sequences and
// a randomized window stream checked against a window-level reference model.
module tb_seg7_scan_decoder;
  localparam int SETTLE = 4;
  localparam int STALE  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_decoder_if bus();

  seg7_scan_decoder #(.SETTLE(SETTLE), .SEG_ACTIVE_LOW(1'b1), .STALE_CYCLES(STALE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [6:0] PAT [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                           7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  logic [6:0] BAD [4]  = '{7'b0000000, 7'b1111110, 7'b0000001, 7'b1000000};

  typedef struct { int b; int c; int e; } frame_t;
  typedef struct { logic [6:0] p [4]; int hold; int nf; int eb; int ec; int ee; } vec_t;
  typedef struct { int d; logic [6:0] pat; int len; } win_t;

  int n_tests = 0;
  int n_fail  = 0;
  frame_t dut_q [$];

  always @(negedge clk)
    if (bus.frame_valid)
      dut_q.push_back('{int'(bus.bottle_count), int'(bus.cork_count), int'(bus.frame_err)});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // en: active-high set of enabled digits; pat: active-high segments
  task automatic drive(input logic [3:0] en, input logic [6:0] pat, input int len);
    bus.seg_in = ~pat;
    {bus.dig3, bus.dig2, bus.dig1, bus.dig0} = ~en;
    tick(len);
  endtask

  task automatic win(input int d, input logic [6:0] pat, input int len);
    logic [3:0] en;
    en = 4'd0;
    if (d >= 0) en[d] = 1'b1;
    drive(en, pat, len);
  endtask

  task automatic blank(input int len);
    drive(4'd0, 7'd0, len);
  endtask

  task automatic scan(input logic [6:0] p0, p1, p2, p3, input int hold);
    win(0, p0, hold); win(1, p1, hold); win(2, p2, hold); win(3, p3, hold);
    blank(4);
  endtask

  task automatic do_reset();
    blank(0);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  function automatic frame_t last_frame();
    frame_t f;
    f = '{-1, -1, -1};
    if (dut_q.size() > 0) f = dut_q[$];
    return f;
  endfunction

  function automatic vec_t mk(input logic [6:0] a, b, c, d, input int hold, nf, eb, ec, ee);
    vec_t v;
    v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
    v.hold = hold; v.nf = nf; v.eb = eb; v.ec = ec; v.ee = ee;
    return v;
  endfunction

  initial begin
    vec_t   tbl [9];
    win_t   wq [$];
    frame_t exp_q [$];
    frame_t f;
    int     n0, first;

    // ---------------- reset state
    blank(0);
    rst = 1'b1;
    tick(3);
    check("rst_frame_valid", 32'(bus.frame_valid), 0);
    check("rst_bottle", 32'(bus.bottle_count), 0);
    check("rst_cork", 32'(bus.cork_count), 0);
    check("rst_frame_err", 32'(bus.frame_err), 0);
    check("rst_bus_err", 32'(bus.bus_err), 0);
    check("rst_stale", 32'(bus.stale), 0);
    rst = 1'b0;

    // ---------------- publish latency after the fourth digit settles
    win(0, PAT[1], 8); win(1, PAT[2], 8); win(2, PAT[0], 8);
    bus.seg_in = ~PAT[5];
    {bus.dig3, bus.dig2, bus.dig1, bus.dig0} = 4'b0111;
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.frame_valid && first < 0) first = k;
    end
    check("latency", first, SETTLE + 2);
    f = last_frame();
    check("latency_bottle", f.b, 12);
    check("latency_cork", f.c, 5);
    tick(1);
    blank(4);

    // ---------------- vector table
    tbl[0] = mk(PAT[1], PAT[2], PAT[0], PAT[5], 8, 1, 12, 5, 0);
    tbl[1] = mk(PAT[1], BAD[0], PAT[0], PAT[5], 8, 1, 12, 5, 1);
    tbl[2] = mk(PAT[9], PAT[9], PAT[3], PAT[9], 8, 1, 99, 39, 0);
    tbl[3] = mk(PAT[9], PAT[9], PAT[3], PAT[9], 8, 1, 99, 39, 0);
    tbl[4] = mk(PAT[9], PAT[9], PAT[3], PAT[9], 20, 1, 99, 39, 0);
    tbl[5] = mk(PAT[4], PAT[6], PAT[7], PAT[8], 5, 1, 46, 78, 0);
    tbl[6] = mk(PAT[0], PAT[0], PAT[0], PAT[0], SETTLE, 1, 0, 0, 0);
    tbl[7] = mk(PAT[3], BAD[1], PAT[1], PAT[1], 6, 1, 0, 0, 1);
    tbl[8] = mk(PAT[8], PAT[0], PAT[9], PAT[9], 8, 1, 80, 99, 0);
    for (int i = 0; i < 9; i++) begin
      n0 = dut_q.size();
      scan(tbl[i].p[0], tbl[i].p[1], tbl[i].p[2], tbl[i].p[3], tbl[i].hold);
      f = last_frame();
      check($sformatf("tbl%0d_frames", i), dut_q.size() - n0, tbl[i].nf);
      check($sformatf("tbl%0d_bottle", i), f.b, tbl[i].eb);
      check($sformatf("tbl%0d_cork", i), f.c, tbl[i].ec);
      check($sformatf("tbl%0d_err", i), f.e, tbl[i].ee);
    end

    // ---------------- window one cycle short of SETTLE is ignored
    n0 = dut_q.size();
    win(0, PAT[9], 8); win(1, PAT[1], 8); win(2, PAT[4], 8);
    win(3, PAT[2], SETTLE - 1);
    blank(6);
    check("short_no_frame", dut_q.size() - n0, 0);
    win(3, PAT[2], 8);
    blank(4);
    f = last_frame();
    check("short_then_frame", dut_q.size() - n0, 1);
    check("short_bottle", f.b, 91);
    check("short_cork", f.c, 42);

    // ---------------- reset in the middle of a capture
    win(0, PAT[3], 8); win(1, PAT[3], 8);
    do_reset();
    check("midrst_bottle", 32'(bus.bottle_count), 0);
    check("midrst_cork", 32'(bus.cork_count), 0);
    check("midrst_frame_valid", 32'(bus.frame_valid), 0);
    n0 = dut_q.size();
    win(2, PAT[1], 8); win(3, PAT[7], 8);
    blank(6);
    check("midrst_mask_cleared", dut_q.size() - n0, 0);
    scan(PAT[4], PAT[2], PAT[1], PAT[7], 8);
    f = last_frame();
    check("midrst_frames", dut_q.size() - n0, 1);
    check("midrst_new_bottle", f.b, 42);
    check("midrst_new_cork", f.c, 17);
    check("bus_err_clean", 32'(bus.bus_err), 0);

    // ---------------- two enables at once
    do_reset();
    drive(4'b0101, PAT[8], 1);
    blank(3);
    check("bus_err_set", 32'(bus.bus_err), 1);
    n0 = dut_q.size();
    drive(4'b0101, PAT[8], 8);
    win(1, PAT[8], 8); win(3, PAT[8], 8);
    blank(6);
    check("bus_err_no_capture", dut_q.size() - n0, 0);
    check("bus_err_sticky", 32'(bus.bus_err), 1);
    do_reset();
    check("bus_err_rst", 32'(bus.bus_err), 0);

    // ---------------- stale timer
    tick(STALE - 1);
    check("stale_before", 32'(bus.stale), 0);
    tick(1);
    check("stale_at_limit", 32'(bus.stale), 1);
    tick(20);
    check("stale_saturated", 32'(bus.stale), 1);
    n0 = dut_q.size();
    scan(PAT[5], PAT[5], PAT[6], PAT[6], 8);
    check("stale_frame", dut_q.size() - n0, 1);
    check("stale_cleared", 32'(bus.stale), 0);

    // ---------------- randomized window stream vs reference model
    do_reset();
    dut_q.delete();
    for (int i = 0; i < 300; i++) begin
      win_t w;
      if ($urandom_range(0, 9) < 2) begin
        w.d = -1; w.pat = 7'd0; w.len = $urandom_range(1, 3);
      end else begin
        w.d   = $urandom_range(0, 3);
        w.pat = ($urandom_range(0, 9) == 0) ? BAD[$urandom_range(0, 3)] : PAT[$urandom_range(0, 9)];
        w.len = $urandom_range(2, 8);
      end
      wq.push_back(w);
    end
    foreach (wq[i]) win(wq[i].d, wq[i].pat, wq[i].len);
    blank(10);

    begin
      int prev_b, prev_c, i, j, len, val [4];
      bit mask [4], inv [4];
      prev_b = 0; prev_c = 0;
      for (int k = 0; k < 4; k++) begin mask[k] = 0; inv[k] = 0; val[k] = 0; end
      i = 0;
      while (i < wq.size()) begin
        len = wq[i].len;
        j = i + 1;
        while (j < wq.size() && wq[j].d == wq[i].d && wq[j].pat == wq[i].pat) begin
          len += wq[j].len;
          j++;
        end
        if (wq[i].d >= 0 && len >= SETTLE && !mask[wq[i].d]) begin
          int v, d;
          d = wq[i].d;
          v = -1;
          for (int k = 0; k < 10; k++) if (PAT[k] == wq[i].pat) v = k;
          inv[d]  = (v < 0);
          val[d]  = (v < 0) ? 0 : v;
          mask[d] = 1;
          if (mask[0] && mask[1] && mask[2] && mask[3]) begin
            int e;
            e = (inv[0] || inv[1] || inv[2] || inv[3]) ? 1 : 0;
            if (e == 0) begin
              prev_b = val[0] * 10 + val[1];
              prev_c = val[2] * 10 + val[3];
            end
            exp_q.push_back('{prev_b, prev_c, e});
            for (int k = 0; k < 4; k++) begin mask[k] = 0; inv[k] = 0; end
          end
        end
        i = j;
      end
    end

    check("rand_frame_count", dut_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < dut_q.size(); k++) begin
      check($sformatf("rand%0d_bottle", k), dut_q[k].b, exp_q[k].b);
      check($sformatf("rand%0d_cork", k), dut_q[k].c, exp_q[k].c);
      check($sformatf("rand%0d_err", k), dut_q[k].e, exp_q[k].e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive end of the multiplexed four-digit 7-segment display bus: OUT[6:0] plus dig0..dig3.
- Samples the time-multiplexed segment pattern for each digit once it has settled and decodes it back to a BCD digit.
- After all four digits are captured, publishes the bottle count (digits 0,1) and cork count (digits 2,3) with a one-cycle frame strobe.
- Used as an on-board monitor / loopback checker for the display path and as a testbench reference model.

Parameters:
SETTLE, 4, consecutive identical cycles (same enable, same segments) required before a digit is captured; legal range 1..255.
SEG_ACTIVE_LOW, 1, 1: segment lit when its seg_in bit is 0; 0: lit when 1.
STALE_CYCLES, 65535, cycles without a completed frame before stale asserts; legal range 1..2^20-1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
seg_in  in  7  segment bus; bit0=a, bit1=b, ..., bit6=g
dig0  in  1  digit 0 enable (bottle tens), active-low
dig1  in  1  digit 1 enable (bottle units), active-low
dig2  in  1  digit 2 enable (cork tens), active-low
dig3  in  1  digit 3 enable (cork units), active-low
frame_valid  out  1  one-cycle pulse when a full frame is published
bottle_count  out  7  tens*10+units from digits 0,1, range 0..99
cork_count  out  7  tens*10+units from digits 2,3, range 0..99
frame_err  out  1  last published frame contained an undecodable pattern
bus_err  out  1  sticky; set when more than one digit enable is active in a cycle
stale  out  1  no frame completed in the last STALE_CYCLES cycles

Behaviour:
- Reset: all outputs 0, capture mask 0, digit registers 0, stability and stale counters 0. rst overrides all other inputs in its cycle.
- Sampling: seg_in and dig0..3 are registered once at input (1-cycle input latency). Segments are normalised to active-high using SEG_ACTIVE_LOW.
- Active digit: exactly one of dig0..3 low. If none is low (blanking), the stability counter clears and nothing is captured.
- If more than one is low: the stability counter clears, bus_err is set and holds until rst, and nothing is captured.
- Stability: the counter increments each cycle the registered enable and segments equal the previous cycle's. It clears to 0 on any change.
- Capture: when the counter reaches SETTLE-1 and the digit's mask bit is 0, the decoded value is written to that digit register and the mask bit is set.
  - Only one capture per enable window; the same window never re-captures.
  - A digit whose mask bit is already 1 is not overwritten until the next frame.
- Decode, exact patterns (active-high, g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Any other pattern, including all-off, decodes to value 0 with that digit's invalid flag set.
- Frame publish: the cycle after the mask reaches 1111, the block does all of the following together:
  - pulses frame_valid;
  - updates bottle_count and cork_count;
  - sets frame_err to the OR of the four invalid flags;
  - clears the mask and the invalid flags.
- If frame_err=1, bottle_count and cork_count keep their previous values; only frame_err updates.
- Capture and publish in the same cycle: the publish uses the pre-capture register contents. A capture into the freshly cleared mask is kept for the next frame.
- Latency: publish occurs SETTLE+2 cycles after the fourth digit's enable and segments become stable at the ports.
- Stale: the counter clears on each frame_valid and saturates at STALE_CYCLES. stale=1 while the counter equals STALE_CYCLES and clears in the cycle after the next frame_valid.
- Arithmetic: count = tens*10 + units, computed combinationally from the 4-bit registers, then registered at publish. No wrap is possible, since the maximum is 99.

Test Plan:
- rst held 3 cycles mid-capture (mask=0011) -> all outputs 0, mask 0; the next full scan publishes normally.
- SETTLE=4, active-low patterns for digits "1","2","0","5" on dig0..3, each held 8 cycles, in order -> one frame_valid; bottle_count=12, cork_count=5, frame_err=0.
- Scan "9","9","3","9" repeated 3 times -> 3 frame_valid pulses, each with bottle_count=99 and cork_count=39; exactly one capture per window.
- Digit window held only SETTLE-1 cycles -> no capture, no frame_valid. A following 8-cycle window captures.
- dig1 pattern 0000000 (blank, active-high) within a scan -> frame_valid with frame_err=1; counts keep their previous 12/5.
- dig0 and dig2 low together for 1 cycle -> bus_err=1 sticky until rst, no capture. After STALE_CYCLES=100 idle cycles -> stale=1; the next good frame clears it.
